blue_motion: RTL and testbench

- Motion controller for the blue character. It consumes the 4-bit per-side collision flags produced by the collision checker and the player keys, and produces the character's top-left position (x_blue, y_blue).
- That position is fed back to the collision checker and to the renderer.
- Updates once per frame tick. A three-state vertical FSM (grounded / rising / falling) implements jump and gravity.

---
 rtl/game_pkg.sv | 26 ++
 rtl/blue_vmotion.sv | 108 ++++++++++
 rtl/blue_motion.sv | 90 +++++++++
 tb/tb_blue_motion.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the character motion blocks: vertical state
// encoding, screen/sprite geometry and collision flag bit positions.
package game_pkg;

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b01,
    ST_FALL   = 2'b10
  } vstate_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPRITE_W = 47;
  localparam int SPRITE_H = 41;

  // Largest top-left coordinate that keeps the whole sprite on screen.
  localparam logic [9:0] X_MAX_DEF = 10'(SCREEN_W - SPRITE_W);
  localparam logic [8:0] Y_MAX_DEF = 9'(SCREEN_H - SPRITE_H);

  // Bit positions inside the 4-bit collision vector.
  localparam int COL_DOWN  = 0;
  localparam int COL_UP    = 1;
  localparam int COL_RIGHT = 2;
  localparam int COL_LEFT  = 3;

endpackage

// File: rtl/blue_vmotion.sv
// Vertical motion of the blue character: grounded/rising/falling FSM with
// jump launch, gravity, terminal speed and screen-edge clamping.
module blue_vmotion
  import game_pkg::*;
#(
  parameter logic [8:0] Y_INIT = 9'd300,
  parameter logic [3:0] JUMP_V = 4'd8,
  parameter logic [3:0] GRAV   = 4'd1,
  parameter logic [3:0] V_MAX  = 4'd8,
  parameter logic [8:0] Y_MAX  = Y_MAX_DEF
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_tick,
  input  logic       i_key_jump,
  input  logic       i_armed,
  input  logic [3:0] i_col,
  output logic [8:0] o_y,
  output logic [1:0] o_state,
  output logic [3:0] o_vy,
  output logic       o_launch
);

  vstate_e     r_state;
  logic [8:0]  r_y;
  logic [3:0]  r_vy;

  logic        w_can_jump;
  logic [9:0]  w_y_up;
  logic [9:0]  w_y_dn;
  logic [4:0]  w_vy_inc;
  logic [3:0]  w_vy_fall;
  logic        w_hit_top;
  logic        w_hit_bot;

  // Jump needs ground contact, a fresh press and headroom.
  assign w_can_jump = (r_state == ST_GROUND) & i_key_jump & i_armed & ~i_col[COL_UP];
  assign o_launch   = i_tick & w_can_jump;

  // 10-bit y math: the borrow out of the subtract flags y < vy, and the
  // extra carry bit lets the downward sum be compared before clamping.
  assign w_y_up    = {1'b0, r_y} - {6'd0, r_vy};
  assign w_y_dn    = {1'b0, r_y} + {6'd0, r_vy};
  assign w_hit_top = w_y_up[9];
  assign w_hit_bot = w_y_dn >= {1'b0, Y_MAX};

  // Gravity with terminal speed while falling.
  assign w_vy_inc  = {1'b0, r_vy} + {1'b0, GRAV};
  assign w_vy_fall = (w_vy_inc > {1'b0, V_MAX}) ? V_MAX : w_vy_inc[3:0];

  // Vertical FSM; everything advances only on frame ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FALL;
      r_y     <= Y_INIT;
      r_vy    <= '0;
    end else if (i_tick) begin
      case (r_state)
        ST_GROUND: begin
          if (w_can_jump) begin
            r_state <= ST_RISE;
            r_vy    <= JUMP_V;
          end else if (!i_col[COL_DOWN]) begin
            // Walked off a ledge: start falling from rest.
            r_state <= ST_FALL;
            r_vy    <= '0;
          end
        end
        ST_RISE: begin
          if (i_col[COL_UP] || (r_vy == '0)) begin
            r_state <= ST_FALL;
            r_vy    <= '0;
          end else if (w_hit_top) begin
            r_y     <= '0;
            r_state <= ST_FALL;
            r_vy    <= '0;
          end else begin
            r_y  <= w_y_up[8:0];
            r_vy <= r_vy - GRAV;
          end
        end
        ST_FALL: begin
          // Floor contact takes priority over any head flag.
          if (i_col[COL_DOWN]) begin
            r_state <= ST_GROUND;
            r_vy    <= '0;
          end else if (w_hit_bot) begin
            r_y     <= Y_MAX;
            r_state <= ST_GROUND;
            r_vy    <= '0;
          end else begin
            r_y  <= w_y_dn[8:0];
            r_vy <= w_vy_fall;
          end
        end
        default: begin
          r_state <= ST_FALL;
          r_vy    <= '0;
        end
      endcase
    end
  end

  assign o_y     = r_y;
  assign o_state = r_state;
  assign o_vy    = r_vy;

endmodule

// File: rtl/blue_motion.sv
// Blue character motion controller: horizontal walking with wall and
// screen-edge limits, jump arming, and the vertical FSM sub-block.
module blue_motion
  import game_pkg::*;
#(
  parameter logic [9:0] X_INIT = 10'd100,
  parameter logic [8:0] Y_INIT = 9'd300,
  parameter logic [9:0] STEP_X = 10'd2,
  parameter logic [3:0] JUMP_V = 4'd8,
  parameter logic [3:0] GRAV   = 4'd1,
  parameter logic [3:0] V_MAX  = 4'd8,
  parameter logic [9:0] X_MAX  = X_MAX_DEF,
  parameter logic [8:0] Y_MAX  = Y_MAX_DEF
)(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic [3:0] is_Collision,
  output logic [9:0] x_blue,
  output logic [8:0] y_blue,
  output logic [1:0] state,
  output logic [3:0] vy
);

  logic [9:0]  r_x;
  logic        r_armed;

  logic        w_go_left;
  logic        w_go_right;
  logic [10:0] w_x_left;
  logic [10:0] w_x_right;
  logic        w_launch;

  // Exactly one direction key, and that side not blocked.
  assign w_go_left  = key_left & ~key_right & ~is_Collision[COL_LEFT];
  assign w_go_right = key_right & ~key_left & ~is_Collision[COL_RIGHT];

  // 11-bit x math so underflow (borrow bit) and overrun are visible.
  assign w_x_left  = {1'b0, r_x} - {1'b0, STEP_X};
  assign w_x_right = {1'b0, r_x} + {1'b0, STEP_X};

  // Horizontal position, saturating at both screen edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= X_INIT;
    end else if (tick) begin
      if (w_go_left) begin
        r_x <= w_x_left[10] ? 10'd0 : w_x_left[9:0];
      end else if (w_go_right) begin
        r_x <= (w_x_right > {1'b0, X_MAX}) ? X_MAX : w_x_right[9:0];
      end
    end
  end

  // Jump arming: a release re-arms, a launch consumes the arm, so a held
  // key yields only one jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b0;
    end else if (tick) begin
      if (w_launch)       r_armed <= 1'b0;
      else if (!key_jump) r_armed <= 1'b1;
    end
  end

  blue_vmotion #(
    .Y_INIT (Y_INIT),
    .JUMP_V (JUMP_V),
    .GRAV   (GRAV),
    .V_MAX  (V_MAX),
    .Y_MAX  (Y_MAX)
  ) u_vmotion (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_tick     (tick),
    .i_key_jump (key_jump),
    .i_armed    (r_armed),
    .i_col      (is_Collision),
    .o_y        (y_blue),
    .o_state    (state),
    .o_vy       (vy),
    .o_launch   (w_launch)
  );

  assign x_blue = r_x;

endmodule

// File: tb/tb_blue_motion.sv
module tb_blue_motion;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       key_left = 1'b0;
  logic       key_right = 1'b0;
  logic       key_jump = 1'b0;
  logic [3:0] is_Collision = 4'b0000;
  logic [9:0] x_blue;
  logic [8:0] y_blue;
  logic [1:0] state;
  logic [3:0] vy;

  int total = 0;
  int bad = 0;

  int mx, my, mst, mvy;
  bit marmed;

  blue_motion dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .key_left(key_left), .key_right(key_right), .key_jump(key_jump),
    .is_Collision(is_Collision),
    .x_blue(x_blue), .y_blue(y_blue), .state(state), .vy(vy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mx = 100; my = 300; mst = 2; mvy = 0; marmed = 0;
  endtask

  task automatic model_tick(input bit l, input bit r, input bit j, input logic [3:0] c);
    int nx, ny, nst, nvy;
    bit narm, launch;
    nx = mx; ny = my; nst = mst; nvy = mvy; narm = marmed;
    if (l && !r && !c[3])      nx = (mx - 2 < 0) ? 0 : mx - 2;
    else if (r && !l && !c[2]) nx = (mx + 2 > 593) ? 593 : mx + 2;
    launch = (mst == 0) && j && marmed && !c[1];
    if (launch) narm = 0;
    else if (!j) narm = 1;
    case (mst)
      0: begin
        if (launch) begin nst = 1; nvy = 8; end
        else if (!c[0]) begin nst = 2; nvy = 0; end
      end
      1: begin
        if (c[1] || mvy == 0) begin nst = 2; nvy = 0; end
        else if (my < mvy) begin ny = 0; nst = 2; nvy = 0; end
        else begin ny = my - mvy; nvy = mvy - 1; end
      end
      default: begin
        if (c[0]) begin nst = 0; nvy = 0; end
        else if (my + mvy >= 439) begin ny = 439; nst = 0; nvy = 0; end
        else begin ny = my + mvy; nvy = (mvy + 1 > 8) ? 8 : mvy + 1; end
      end
    endcase
    mx = nx; my = ny; mst = nst; mvy = nvy; marmed = narm;
  endtask

  function automatic logic [24:0] mexp();
    return {10'(mx), 9'(my), 2'(mst), 4'(mvy)};
  endfunction

  task automatic step(input bit t, input bit l, input bit r, input bit j, input logic [3:0] c);
    @(negedge clk);
    tick = t; key_left = l; key_right = r; key_jump = j; is_Collision = c;
    @(posedge clk);
    if (t) model_tick(l, r, j, c);
    #1 tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({x_blue, y_blue, state, vy} !== {10'd100, 9'd300, 2'b10, 4'd0}) begin
      bad++;
      $display("FAIL reset_values: got x=%0d y=%0d st=%b vy=%0d", x_blue, y_blue, state, vy);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_fall_land();
    int ey[3] = '{300, 301, 303};
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 4'b0000);
      total++;
      if (y_blue !== 9'(ey[k]) || vy !== 4'(k + 1) || state !== 2'b10) begin
        bad++;
        $display("FAIL fall_%0d: got y=%0d vy=%0d st=%b want y=%0d vy=%0d", k, y_blue, vy, state, ey[k], k + 1);
      end
    end
    step(1, 0, 0, 0, 4'b0001);
    total++;
    if (y_blue !== 9'd303 || vy !== 4'd0 || state !== 2'b00) begin
      bad++;
      $display("FAIL land: got y=%0d vy=%0d st=%b want y=303 vy=0 st=00", y_blue, vy, state);
    end
  endtask

  task automatic test_jump_arc();
    int y0, dy;
    step(1, 0, 0, 0, 4'b0001);
    y0 = int'(y_blue);
    step(1, 0, 0, 1, 4'b0001);
    total++;
    if (state !== 2'b01 || vy !== 4'd8 || y_blue !== 9'(y0)) begin
      bad++;
      $display("FAIL jump_launch: got st=%b vy=%0d y=%0d want 01 8 %0d", state, vy, y_blue, y0);
    end
    dy = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 0, 1, 4'b0000);
      dy += 8 - k;
      total++;
      if (y_blue !== 9'(y0 - dy) || vy !== 4'(7 - k) || state !== 2'b01) begin
        bad++;
        $display("FAIL rise_%0d: got y=%0d vy=%0d st=%b want y=%0d vy=%0d", k, y_blue, vy, state, y0 - dy, 7 - k);
      end
    end
    total++;
    if (y0 - int'(y_blue) !== 36) begin
      bad++;
      $display("FAIL jump_height: got %0d want 36", y0 - int'(y_blue));
    end
    step(1, 0, 0, 1, 4'b0000);
    total++;
    if (state !== 2'b10 || vy !== 4'd0 || y_blue !== 9'(y0 - 36)) begin
      bad++;
      $display("FAIL apex: got st=%b vy=%0d y=%0d want 10 0 %0d", state, vy, y_blue, y0 - 36);
    end
    step(1, 0, 0, 1, 4'b0000);
    step(1, 0, 0, 1, 4'b0000);
    step(1, 0, 0, 1, 4'b0001);
    step(1, 0, 0, 1, 4'b0001);
    total++;
    if (state !== 2'b00 || {x_blue, y_blue, state, vy} !== mexp()) begin
      bad++;
      $display("FAIL no_rejump: got st=%b vy=%0d want st=00", state, vy);
    end
  endtask

  task automatic test_head_bump();
    int y0;
    step(1, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 1, 4'b0001);
    repeat (3) step(1, 0, 0, 0, 4'b0000);
    total++;
    if (vy !== 4'd5 || state !== 2'b01) begin
      bad++;
      $display("FAIL pre_bump: got vy=%0d st=%b want 5 01", vy, state);
    end
    y0 = int'(y_blue);
    step(1, 0, 0, 0, 4'b0010);
    total++;
    if (state !== 2'b10 || vy !== 4'd0 || y_blue !== 9'(y0)) begin
      bad++;
      $display("FAIL head_bump: got st=%b vy=%0d y=%0d want 10 0 %0d", state, vy, y_blue, y0);
    end
    step(1, 0, 0, 0, 4'b0011);
    total++;
    if (state !== 2'b00 || {x_blue, y_blue, state, vy} !== mexp()) begin
      bad++;
      $display("FAIL down_wins: got st=%b vy=%0d want st=00", state, vy);
    end
  endtask

  task automatic test_reset_midjump();
    step(1, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 1, 4'b0001);
    step(1, 0, 0, 1, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({x_blue, y_blue, state, vy} !== {10'd100, 9'd300, 2'b10, 4'd0}) begin
      bad++;
      $display("FAIL reset_midjump: got x=%0d y=%0d st=%b vy=%0d", x_blue, y_blue, state, vy);
    end
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    step(1, 0, 0, 0, 4'b0001);
  endtask

  task automatic test_walls();
    repeat (245) step(1, 0, 1, 0, 4'b0001);
    step(1, 0, 1, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd592) begin bad++; $display("FAIL right_592: got %0d want 592", x_blue); end
    step(1, 0, 1, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd593) begin bad++; $display("FAIL right_sat: got %0d want 593", x_blue); end
    step(1, 0, 1, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd593) begin bad++; $display("FAIL right_hold: got %0d want 593", x_blue); end
    step(1, 1, 0, 0, 4'b0001);
    step(1, 0, 1, 0, 4'b0101);
    total++;
    if (x_blue !== 10'd591) begin bad++; $display("FAIL right_blocked: got %0d want 591", x_blue); end
    step(1, 1, 1, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd591) begin bad++; $display("FAIL both_keys: got %0d want 591", x_blue); end
    repeat (295) step(1, 1, 0, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd1) begin bad++; $display("FAIL left_1: got %0d want 1", x_blue); end
    step(1, 1, 0, 0, 4'b0001);
    total++;
    if (x_blue !== 10'd0) begin bad++; $display("FAIL left_sat: got %0d want 0", x_blue); end
    step(1, 0, 1, 0, 4'b0001);
    step(1, 1, 0, 0, 4'b1001);
    total++;
    if (x_blue !== 10'd2 || {x_blue, y_blue, state, vy} !== mexp()) begin
      bad++;
      $display("FAIL left_blocked: got %0d want 2", x_blue);
    end
  endtask

  task automatic test_tick_gating();
    int y0;
    for (int k = 0; k < 10; k++) begin
      step(0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      total++;
      if ({x_blue, y_blue, state, vy} !== mexp()) begin
        bad++;
        $display("FAIL no_tick_%0d: got %h want %h", k, {x_blue, y_blue, state, vy}, mexp());
      end
    end
    y0 = int'(y_blue);
    step(1, 0, 0, 0, 4'b0000);
    total++;
    if (state !== 2'b10 || vy !== 4'd0 || y_blue !== 9'(y0)) begin
      bad++;
      $display("FAIL walk_off: got st=%b vy=%0d y=%0d want 10 0 %0d", state, vy, y_blue, y0);
    end
  endtask

  task automatic test_random();
    logic [3:0] c;
    for (int k = 0; k < 2000; k++) begin
      c = 4'($urandom);
      if ($urandom_range(0, 2) != 0) c[0] = 1'b0;
      if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
      step(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 2) == 0), c);
      total++;
      if ({x_blue, y_blue, state, vy} !== mexp()) begin
        bad++;
        $display("FAIL random_%0d: got x=%0d y=%0d st=%b vy=%0d want %h", k, x_blue, y_blue, state, vy, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_land();
    test_jump_arc();
    test_head_bump();
    test_reset_midjump();
    test_walls();
    test_tick_gating();
    test_random();
    if (bad == 0) $display("PASS test done: total=%0d bad=%0d", total, bad);
    else          $display("FAIL test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
